// File: rtl/alu.sv
// Five-bit bring-up execution unit: decodes an RV32I/M R- or I-type word,
// uses the rs1/rs2/imm field values as operands and registers a 5-bit result.
module alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] code,
    output logic [4:0]  rd
);

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] F7_STD = 7'b0000000;
    localparam logic [6:0] F7_ALT = 7'b0100000;
    localparam logic [6:0] F7_MUL = 7'b0000001;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] res;
    logic       unused_dest;

    assign opcode = code[6:0];
    assign funct3 = code[14:12];
    assign funct7 = code[31:25];
    assign a      = code[19:15];
    assign b      = code[24:20];

    // The destination register field has no meaning without a register file.
    assign unused_dest = ^code[11:7];

    always_comb begin
        res = 5'b00000;
        unique case (opcode)
            OP_R: begin
                unique case ({funct7, funct3})
                    {F7_STD, 3'b000}: res = a + b;
                    {F7_ALT, 3'b000}: res = a - b;
                    {F7_MUL, 3'b000}: res = a * b;
                    {F7_STD, 3'b001}: res = a << b;
                    {F7_STD, 3'b010}: res = {4'b0000, $signed(a) < $signed(b)};
                    {F7_STD, 3'b011}: res = {4'b0000, a < b};
                    {F7_STD, 3'b100}: res = a ^ b;
                    {F7_STD, 3'b101}: res = a >> b;
                    {F7_ALT, 3'b101}: res = $signed(a) >>> b;
                    {F7_STD, 3'b110}: res = a | b;
                    {F7_STD, 3'b111}: res = a & b;
                    default:          res = 5'b00000;
                endcase
            end
            OP_I: begin
                // imm[11:5] shares the funct7 bit positions and only qualifies shifts.
                unique case (funct3)
                    3'b000: res = a + b;
                    3'b010: res = {4'b0000, $signed(a) < $signed(b)};
                    3'b011: res = {4'b0000, a < b};
                    3'b100: res = a ^ b;
                    3'b110: res = a | b;
                    3'b111: res = a & b;
                    3'b001: res = (funct7 == F7_STD) ? (a << b) : 5'b00000;
                    3'b101: begin
                        if (funct7 == F7_STD)
                            res = a >> b;
                        else if (funct7 == F7_ALT)
                            res = $signed(a) >>> b;
                        else
                            res = 5'b00000;
                    end
                    default: res = 5'b00000;
                endcase
            end
            default: res = 5'b00000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            rd <= 5'b00000;
        else
            rd <= res;
    end

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the 5-bit alu: fixed instruction words
// with hand-computed results, checked one edge after they are applied.
module tb_alu;

    logic        clk;
    logic        rst;
    logic [31:0] code;
    logic [4:0]  rd;

    int checks = 0;
    int passed = 0;

    alu dut (
        .clk  (clk),
        .rst  (rst),
        .code (code),
        .rd   (rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [4:0] rs2,
                                       input logic [4:0] rs1, input logic [2:0] f3,
                                       input logic [6:0] op);
        return {f7, rs2, rs1, f3, 5'b10101, op};
    endfunction

    task automatic check(input string tag, input logic [4:0] exp);
        checks++;
        assert (rd === exp) passed++;
        else $error("FAIL %s: rd=%b expected %b", tag, rd, exp);
    endtask

    // Apply a word with the given reset level, clock it in, check one edge later.
    task automatic step(input string tag, input logic r, input logic [31:0] c,
                        input logic [4:0] exp);
        rst  = r;
        code = c;
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    initial begin
        rst  = 1'b1;
        code = 32'h0041_0033;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset", 5'b00000);

        step("release_add", 1'b0, 32'h0041_0033, 5'b00110);

        step("add",  1'b0, 32'h0041_0033, 5'b00110);
        step("sub",  1'b0, 32'h4041_0033, 5'b11110);
        step("mul",  1'b0, 32'h0241_0033, 5'b01000);
        step("and",  1'b0, 32'h0041_7033, 5'b00000);
        step("or",   1'b0, 32'h0061_6033, 5'b00110);
        step("xor",  1'b0, 32'h0061_4033, 5'b00100);
        step("slt",  1'b0, 32'h003D_A033, 5'b00001);
        step("sltu", 1'b0, 32'h003D_B033, 5'b00000);
        step("sra",  1'b0, 32'h401D_5033, 5'b11101);
        step("srl",  1'b0, 32'h0011_D033, 5'b00001);
        step("sll",  1'b0, 32'h0011_9033, 5'b00110);

        step("addi",  1'b0, 32'h0033_8013, 5'b01010);
        step("andi",  1'b0, 32'h0022_7013, 5'b00000);
        step("ori",   1'b0, 32'h0023_6013, 5'b00110);
        step("xori",  1'b0, 32'h0023_4013, 5'b00100);
        step("slti",  1'b0, 32'h003D_A013, 5'b00001);
        step("sltiu", 1'b0, 32'h003D_B013, 5'b00000);
        step("srai",  1'b0, 32'h401D_5013, 5'b11101);
        step("srli",  1'b0, 32'h0011_D013, 5'b00001);
        step("slli",  1'b0, 32'h0011_9013, 5'b00110);

        // Boundaries: wrap, oversize shifts, sign edges, illegal encodings.
        step("add_wrap",   1'b0, mk(7'h00, 5'd1,  5'd31, 3'b000, 7'b0110011), 5'b00000);
        step("sub_wrap",   1'b0, mk(7'h20, 5'd1,  5'd0,  3'b000, 7'b0110011), 5'b11111);
        step("mul_wrap",   1'b0, mk(7'h01, 5'd7,  5'd6,  3'b000, 7'b0110011), 5'b01010);
        step("sll_by7",    1'b0, mk(7'h00, 5'd7,  5'd3,  3'b001, 7'b0110011), 5'b00000);
        step("srl_by5",    1'b0, mk(7'h00, 5'd5,  5'd31, 3'b101, 7'b0110011), 5'b00000);
        step("sra_by9",    1'b0, mk(7'h20, 5'd9,  5'd16, 3'b101, 7'b0110011), 5'b11111);
        step("srai_by31p", 1'b0, mk(7'h20, 5'd31, 5'd15, 3'b101, 7'b0010011), 5'b00000);
        step("sll_by0",    1'b0, mk(7'h00, 5'd0,  5'd19, 3'b001, 7'b0110011), 5'b10011);
        step("slt_minmax", 1'b0, mk(7'h00, 5'd15, 5'd16, 3'b010, 7'b0110011), 5'b00001);
        step("sltu_minmax",1'b0, mk(7'h00, 5'd15, 5'd16, 3'b011, 7'b0110011), 5'b00000);
        step("bad_opcode", 1'b0, mk(7'h00, 5'd4,  5'd2,  3'b000, 7'b0000011), 5'b00000);
        step("bad_funct7", 1'b0, mk(7'h03, 5'd4,  5'd2,  3'b000, 7'b0110011), 5'b00000);
        step("bad_mulh",   1'b0, mk(7'h01, 5'd4,  5'd2,  3'b001, 7'b0110011), 5'b00000);
        step("bad_slli",   1'b0, mk(7'h01, 5'd1,  5'd3,  3'b001, 7'b0010011), 5'b00000);
        step("bad_srxi",   1'b0, mk(7'h21, 5'd1,  5'd3,  3'b101, 7'b0010011), 5'b00000);

        // A code change between edges must not reach rd until the next edge.
        step("hold_pre", 1'b0, 32'h0041_0033, 5'b00110);
        code = 32'h4041_0033;
        #2;
        check("hold_mid", 5'b00110);
        @(posedge clk);
        #1;
        check("hold_post", 5'b11110);

        step("rst_prio",   1'b1, 32'h4041_0033, 5'b00000);
        step("rst_deassert", 1'b0, 32'h0061_6033, 5'b00110);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
